// File: rtl/scmp_alu_if.sv
// +-----------------------------------------------------------------------------+
// | scmp_alu_if : sequencer <-> ALU op/result bundle for scmp_alu_seq           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface scmp_alu_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [3:0]        op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              cy_i;
   logic              ov_i;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] res_hi;
   logic              cy_o;
   logic              ov_o;
   logic              cy_sgn_o;

   modport master (
      output start, op, a, b, cy_i, ov_i,
      input  busy, done, res, res_hi, cy_o, ov_o, cy_sgn_o
   );

   modport slave (
      input  start, op, a, b, cy_i, ov_i,
      output busy, done, res, res_hi, cy_o, ov_o, cy_sgn_o
   );
endinterface

`default_nettype wire

// File: rtl/scmp_alu_seq.sv
// +-----------------------------------------------------------------------------+
// | scmp_alu_seq : registered SC/MP ALU with BCD add and iterative MUL/DIV      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module scmp_alu_seq #(
   parameter int DATA_W    = 8,
   parameter int EN_MULDIV = 1
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   scmp_alu_if.slave   bus
);

   localparam int MSB   = DATA_W - 1;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(DATA_W - 1);
   localparam bit               C_MULDIV  = (EN_MULDIV != 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_AND    = 4'd0;
   localparam logic [3:0] OP_OR     = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_ADD    = 4'd3;
   localparam logic [3:0] OP_ADD_NC = 4'd4;
   localparam logic [3:0] OP_DAD    = 4'd5;
   localparam logic [3:0] OP_RRL    = 4'd6;
   localparam logic [3:0] OP_SRL    = 4'd7;
   localparam logic [3:0] OP_INC    = 4'd8;
   localparam logic [3:0] OP_DEC    = 4'd9;
   localparam logic [3:0] OP_PASS_B = 4'd10;
   localparam logic [3:0] OP_MUL    = 4'd12;
   localparam logic [3:0] OP_DIV    = 4'd13;

   // Returns {carry_out, bcd_sum}; each nibble is corrected independently.
   function automatic logic [DATA_W:0] f_dad(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y,
                                             input logic              c);
      logic [DATA_W-1:0] s;
      logic              cc;
      logic [4:0]        n;
      s  = '0;
      cc = c;
      for (int i = 0; i < DATA_W / 4; i++) begin
         n = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'd0, cc};
         if (n > 5'd9) begin
            n  = n + 5'd6;
            cc = 1'b1;
         end else begin
            cc = 1'b0;
         end
         s[4*i +: 4] = n[3:0];
      end
      return {cc, s};
   endfunction

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_mul;
   logic [DATA_W-1:0] r_opnd;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_res;
   logic [DATA_W-1:0] r_res_hi;
   logic              r_cy;
   logic              r_ov;
   logic              r_cy_sgn;

   logic              w_add_cin;
   logic [DATA_W:0]   w_add;
   logic [DATA_W:0]   w_inc;
   logic [DATA_W:0]   w_dad;
   logic              w_b_zero;
   logic              w_go_iter;
   logic [DATA_W-1:0] w_res;
   logic [DATA_W-1:0] w_hi;
   logic              w_cy;
   logic              w_ov;
   logic              w_sgn;

   assign w_add_cin = (bus.op == OP_ADD) & bus.cy_i;
   assign w_add     = {1'b0, bus.a} + {1'b0, bus.b} + {{DATA_W{1'b0}}, w_add_cin};
   assign w_inc     = {1'b0, bus.a} + (DATA_W+1)'(1);
   assign w_dad     = f_dad(bus.a, bus.b, bus.cy_i);
   assign w_b_zero  = (bus.b == '0);
   assign w_go_iter = C_MULDIV & ((bus.op == OP_MUL) | ((bus.op == OP_DIV) & ~w_b_zero));

   always_comb begin
      w_res = bus.a;
      w_hi  = '0;
      w_cy  = bus.cy_i;
      w_ov  = bus.ov_i;
      w_sgn = 1'b0;
      case (bus.op)
         OP_AND:    w_res = bus.a & bus.b;
         OP_OR:     w_res = bus.a | bus.b;
         OP_XOR:    w_res = bus.a ^ bus.b;
         OP_ADD, OP_ADD_NC: begin
            w_res = w_add[MSB:0];
            w_cy  = w_add[DATA_W];
            w_ov  = (bus.a[MSB] == bus.b[MSB]) & (w_add[MSB] != bus.a[MSB]);
            w_sgn = bus.b[MSB];
         end
         OP_DAD: begin
            w_res = w_dad[MSB:0];
            w_cy  = w_dad[DATA_W];
         end
         OP_RRL: begin
            w_res = {bus.cy_i, bus.a[MSB:1]};
            w_cy  = bus.a[0];
         end
         OP_SRL: begin
            w_res = {1'b0, bus.a[MSB:1]};
            w_cy  = bus.a[0];
         end
         OP_INC: begin
            w_res = w_inc[MSB:0];
            w_cy  = w_inc[DATA_W];
         end
         OP_DEC: begin
            w_res = bus.a - 1'b1;
            w_cy  = (bus.a == '0);
         end
         OP_PASS_B: w_res = bus.b;
         OP_DIV: begin
            // Divide-by-zero short-circuits the iterative path.
            if (C_MULDIV && w_b_zero) begin
               w_res = '1;
               w_hi  = bus.a;
               w_cy  = 1'b0;
               w_ov  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // One shift-add (MUL) or restoring-subtract (DIV) step on {r_hi, r_lo}.
   logic [DATA_W:0]   w_madd;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W-1:0] w_nxt_hi;
   logic [DATA_W-1:0] w_nxt_lo;

   assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_shift = {r_hi, r_lo[MSB]};
   assign w_trial = w_shift - {1'b0, r_opnd};

   always_comb begin
      w_nxt_hi = '0;
      w_nxt_lo = '0;
      if (r_is_mul) begin
         w_nxt_hi = w_madd[DATA_W:1];
         w_nxt_lo = {w_madd[0], r_lo[MSB:1]};
      end else if (!w_trial[DATA_W]) begin
         w_nxt_hi = w_trial[MSB:0];
         w_nxt_lo = {r_lo[MSB-1:0], 1'b1};
      end else begin
         w_nxt_hi = w_shift[MSB:0];
         w_nxt_lo = {r_lo[MSB-1:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_mul <= 1'b0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res    <= '0;
         r_res_hi <= '0;
         r_cy     <= 1'b0;
         r_ov     <= 1'b0;
         r_cy_sgn <= 1'b0;
      end else begin
         case (r_state)
            S_ITER: begin
               r_hi  <= w_nxt_hi;
               r_lo  <= w_nxt_lo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  r_state  <= S_DONE;
                  r_res    <= w_nxt_lo;
                  r_res_hi <= w_nxt_hi;
                  r_cy     <= 1'b0;
                  r_ov     <= r_is_mul & (w_nxt_hi != '0);
                  r_cy_sgn <= 1'b0;
               end
            end
            default: begin
               if (bus.start) begin
                  if (w_go_iter) begin
                     r_state  <= S_ITER;
                     r_cnt    <= '0;
                     r_is_mul <= (bus.op == OP_MUL);
                     r_opnd   <= (bus.op == OP_MUL) ? bus.a : bus.b;
                     r_lo     <= (bus.op == OP_MUL) ? bus.b : bus.a;
                     r_hi     <= '0;
                  end else begin
                     r_state  <= S_DONE;
                     r_res    <= w_res;
                     r_res_hi <= w_hi;
                     r_cy     <= w_cy;
                     r_ov     <= w_ov;
                     r_cy_sgn <= w_sgn;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy     = (r_state == S_ITER);
   assign bus.done     = (r_state == S_DONE);
   assign bus.res      = r_res;
   assign bus.res_hi   = r_res_hi;
   assign bus.cy_o     = r_cy;
   assign bus.ov_o     = r_ov;
   assign bus.cy_sgn_o = r_cy_sgn;

endmodule

`default_nettype wire

// File: tb/tb_scmp_alu_seq.sv
// +-----------------------------------------------------------------------------+
// | tb_scmp_alu_seq : directed + random scoreboard bench for scmp_alu_seq (W=8) |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_scmp_alu_seq;

   typedef struct packed {
      logic [7:0] res;
      logic [7:0] hi;
      logic       cy;
      logic       ov;
      logic       sgn;
      int         lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   exp_t sb[$];

   scmp_alu_if #(.DATA_W(8)) bus ();

   scmp_alu_seq #(.DATA_W(8), .EN_MULDIV(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   // Reference behaviour built from plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cy, input logic ov);
      exp_t e;
      int   s;
      int   ss;
      int   cin;
      e.res = a; e.hi = 8'h00; e.cy = cy; e.ov = ov; e.sgn = 1'b0; e.lat = 1;
      case (op)
         4'd0: e.res = a & b;
         4'd1: e.res = a | b;
         4'd2: e.res = a ^ b;
         4'd3, 4'd4: begin
            cin   = (op == 4'd3) ? int'(cy) : 0;
            s     = int'(a) + int'(b) + cin;
            ss    = int'($signed(a)) + int'($signed(b)) + cin;
            e.res = 8'(s);
            e.cy  = (s > 255);
            e.ov  = (ss > 127) || (ss < -128);
            e.sgn = b[7];
         end
         4'd5: begin
            s     = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]) + int'(cy);
            e.cy  = (s >= 100);
            s     = s % 100;
            e.res = {4'(s / 10), 4'(s % 10)};
         end
         4'd6: begin e.res = {cy, a[7:1]}; e.cy = a[0]; end
         4'd7: begin e.res = {1'b0, a[7:1]}; e.cy = a[0]; end
         4'd8: begin s = int'(a) + 1; e.res = 8'(s); e.cy = (s > 255); end
         4'd9: begin e.res = 8'(int'(a) - 1); e.cy = (a == 8'h00); end
         4'd10: e.res = b;
         4'd12: begin
            s     = int'(a) * int'(b);
            e.res = 8'(s);
            e.hi  = 8'(s / 256);
            e.cy  = 1'b0;
            e.ov  = (e.hi != 8'h00);
            e.lat = 9;
         end
         4'd13: begin
            e.cy = 1'b0;
            if (b == 8'h00) begin
               e.res = 8'hFF; e.hi = a; e.ov = 1'b1;
            end else begin
               e.res = 8'(int'(a) / int'(b));
               e.hi  = 8'(int'(a) % int'(b));
               e.ov  = 1'b0;
               e.lat = 9;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Issue one op, scramble inputs while it runs, optionally poke start mid-busy,
   // then pop the scoreboard at the done pulse. Returns in the done cycle.
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cy, input logic ov, input bit poke);
      exp_t e;
      int   t0;
      int   busy_n;
      bit   got;
      sb.push_back(model(op, a, b, cy, ov));
      bus.op = op; bus.a = a; bus.b = b; bus.cy_i = cy; bus.ov_i = ov; bus.start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 4'($urandom_range(0, 11));
      bus.cy_i = 1'($urandom); bus.ov_i = 1'($urandom);
      got = 1'b0; busy_n = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         if (bus.busy) busy_n++;
         if (poke && k == 3) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      e = sb.pop_front();
      chk($sformatf("done_seen op%0d", op), 32'(got), 32'd1);
      if (got) begin
         chk($sformatf("latency op%0d", op), 32'(cyc - t0), 32'(e.lat));
         chk($sformatf("busy_cycles op%0d", op), 32'(busy_n), 32'(e.lat - 1));
         chk($sformatf("res op%0d", op), 32'(bus.res), 32'(e.res));
         chk($sformatf("res_hi op%0d", op), 32'(bus.res_hi), 32'(e.hi));
         chk($sformatf("cy_o op%0d", op), 32'(bus.cy_o), 32'(e.cy));
         chk($sformatf("ov_o op%0d", op), 32'(bus.ov_o), 32'(e.ov));
         chk($sformatf("cy_sgn op%0d", op), 32'(bus.cy_sgn_o), 32'(e.sgn));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_res"}, 32'(bus.res), 32'd0);
      chk({tag, "_res_hi"}, 32'(bus.res_hi), 32'd0);
      chk({tag, "_cy"}, 32'(bus.cy_o), 32'd0);
      chk({tag, "_ov"}, 32'(bus.ov_o), 32'd0);
      chk({tag, "_sgn"}, 32'(bus.cy_sgn_o), 32'd0);
   endtask

   initial begin
      int         dones;
      logic [3:0] rop;
      logic [7:0] ra;
      logic [7:0] rb;
      cyc = 0; n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
      bus.cy_i = 1'b0; bus.ov_i = 1'b0;

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst");
      rst_n = 1'b1;

      // Reset mid-multiply abandons the op
      @(posedge clk); #1;
      bus.op = 4'd12; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_mul_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_zero("rst_mid");
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      chk("no_done_after_rst", 32'(dones), 32'd0);

      // ADD signed overflow and signed displacement
      run_op(4'd3, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      chk("add1_res_const", 32'(bus.res), 32'h80);
      chk("add1_ov_const", 32'(bus.ov_o), 32'd1);
      run_op(4'd3, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b0);
      chk("add2_cy_const", 32'(bus.cy_o), 32'd1);
      chk("add2_sgn_const", 32'(bus.cy_sgn_o), 32'd1);

      // DAD
      run_op(4'd5, 8'h59, 8'h48, 1'b1, 1'b1, 1'b0);
      chk("dad1_res_const", 32'(bus.res), 32'h08);
      run_op(4'd5, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      chk("dad2_res_const", 32'(bus.res), 32'h46);

      // MUL with a start poke while busy (must be ignored)
      run_op(4'd12, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
      chk("mul_res_const", 32'({bus.res_hi, bus.res}), 32'hFE01);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("res_held", 32'(bus.res), 32'h01);
      chk("no_queued_op", 32'(bus.busy), 32'd0);

      // DIV and divide by zero
      run_op(4'd13, 8'd200, 8'd7, 1'b1, 1'b1, 1'b0);
      chk("div_res_const", 32'({bus.res_hi, bus.res}), 32'h041C);
      run_op(4'd13, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("div0_res_const", 32'({bus.res_hi, bus.res}), 32'h5AFF);

      // Back-to-back INC then DEC issued in the done cycle
      run_op(4'd8, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      run_op(4'd9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("dec_res_const", 32'(bus.res), 32'hFF);

      // Remaining ops
      run_op(4'd0, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
      run_op(4'd1, 8'hA0, 8'h05, 1'b0, 1'b1, 1'b0);
      run_op(4'd2, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
      run_op(4'd4, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
      run_op(4'd6, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      run_op(4'd7, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0);
      run_op(4'd10, 8'h11, 8'hC3, 1'b1, 1'b1, 1'b0);
      run_op(4'd11, 8'h5E, 8'hC3, 1'b0, 1'b1, 1'b0);
      run_op(4'd15, 8'h77, 8'h12, 1'b1, 1'b0, 1'b0);

      // Random mix
      for (int i = 0; i < 30; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (rop == 4'd5) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         run_op(rop, ra, rb, 1'($urandom), 1'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
